// File: rtl/sram_arbiter_if.sv
// Purpose: requester handshakes (VGA/CPU/DMA) and SRAM pin bundle for sram_arbiter.
// Latency: none, wiring only.
// Backpressure: each requester holds req/addr/we/wdata until its one-cycle ack pulse.
//
// Port summary:
//   vga_*  : read-only requester (req, addr in; ack, rdata out)
//   cpu_*  : read/write requester (req, we, addr, wdata in; ack, rdata out)
//   dma_*  : read/write requester, same shape as cpu_*
//   SRAM_ADDR, SRAM_WE_n, sram_dout, sram_doe : towards the SRAM pins / tristate
//   sram_din : byte read back from the SRAM data pins
//   busy     : arbiter is in the middle of an access
// Modport slave is the arbiter's view, master is the requester/pin side.
interface sram_arbiter_if #(
    parameter int ADDR_W = 21
);
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_ack;
    logic [7:0]        vga_rdata;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_ack;
    logic [7:0]        cpu_rdata;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [7:0]        dma_wdata;
    logic              dma_ack;
    logic [7:0]        dma_rdata;

    logic [ADDR_W-1:0] SRAM_ADDR;
    logic              SRAM_WE_n;
    logic [7:0]        sram_dout;
    logic              sram_doe;
    logic [7:0]        sram_din;
    logic              busy;

    modport slave (
        input  vga_req, vga_addr,
        output vga_ack, vga_rdata,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_ack, dma_rdata,
        output SRAM_ADDR, SRAM_WE_n, sram_dout, sram_doe,
        input  sram_din,
        output busy
    );

    modport master (
        output vga_req, vga_addr,
        input  vga_ack, vga_rdata,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_ack, dma_rdata,
        input  SRAM_ADDR, SRAM_WE_n, sram_dout, sram_doe,
        output sram_din,
        input  busy
    );
endinterface

// File: rtl/sram_arbiter.sv
// Purpose: shares one asynchronous 8-bit SRAM between VGA fetch, CPU and DMA requesters.
// Latency: ACCESS_CYCLES+2 clocks from grant to ack (ADDR, STROBE x N, RECOV), then one IDLE clock.
// Backpressure: requests are levels held until ack; losers simply wait, VGA always wins.
//
// Ports:
//   clk_100  : system clock, all state on the rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : sram_arbiter_if.slave -- requester handshakes plus SRAM pin drive
// Parameters:
//   ADDR_W        : SRAM address width
//   ACCESS_CYCLES : strobe length in clocks, legal range 1..15
module sram_arbiter #(
    parameter int ADDR_W        = 21,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic          clk_100,
    input  logic          reset_n,
    sram_arbiter_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ADDR   = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_RECOV  = 2'd3;

    localparam logic [1:0] PORT_VGA = 2'd0;
    localparam logic [1:0] PORT_CPU = 2'd1;
    localparam logic [1:0] PORT_DMA = 2'd2;

    // Strobe counter runs from this value down to zero.
    localparam logic [3:0] STROBE_LAST = 4'(ACCESS_CYCLES - 1);

    logic [1:0]        state;
    logic [3:0]        strobe_cnt;
    logic [1:0]        gnt_port;
    logic              gnt_we;
    // 1: CPU wins the next CPU/DMA tie, 0: DMA wins it.
    logic              rr_cpu_next;

    logic [ADDR_W-1:0] addr_q;
    logic              we_n_q;
    logic [7:0]        dout_q;
    logic              doe_q;

    logic              vga_ack_q;
    logic              cpu_ack_q;
    logic              dma_ack_q;
    logic [7:0]        vga_rdata_q;
    logic [7:0]        cpu_rdata_q;
    logic [7:0]        dma_rdata_q;

    logic              pick_vld;
    logic [1:0]        pick_port;
    logic              pick_we;
    logic [ADDR_W-1:0] pick_addr;
    logic [7:0]        pick_wdata;
    logic              strobe_done;

    // ------------------------------------------------------------------
    // Arbitration: VGA is absolute, CPU/DMA ties resolved by rr_cpu_next.
    // VGA is read-only, so its grant never carries a write.
    // ------------------------------------------------------------------
    always_comb begin
        pick_vld   = 1'b0;
        pick_port  = PORT_VGA;
        pick_we    = 1'b0;
        pick_addr  = bus.vga_addr;
        pick_wdata = 8'h00;
        if (bus.vga_req) begin
            pick_vld = 1'b1;
        end else if (bus.cpu_req && (!bus.dma_req || rr_cpu_next)) begin
            pick_vld   = 1'b1;
            pick_port  = PORT_CPU;
            pick_we    = bus.cpu_we;
            pick_addr  = bus.cpu_addr;
            pick_wdata = bus.cpu_wdata;
        end else if (bus.dma_req) begin
            pick_vld   = 1'b1;
            pick_port  = PORT_DMA;
            pick_we    = bus.dma_we;
            pick_addr  = bus.dma_addr;
            pick_wdata = bus.dma_wdata;
        end
    end

    assign strobe_done = (state == ST_STROBE) && (strobe_cnt == 4'd0);

    // ------------------------------------------------------------------
    // Access sequencer.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            strobe_cnt  <= 4'd0;
            gnt_port    <= PORT_VGA;
            gnt_we      <= 1'b0;
            rr_cpu_next <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        state    <= ST_ADDR;
                        gnt_port <= pick_port;
                        gnt_we   <= pick_we;
                        // Only CPU/DMA grants move the round-robin pointer.
                        if (pick_port == PORT_CPU) begin
                            rr_cpu_next <= 1'b0;
                        end else if (pick_port == PORT_DMA) begin
                            rr_cpu_next <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    state      <= ST_STROBE;
                    strobe_cnt <= STROBE_LAST;
                end
                ST_STROBE: begin
                    if (strobe_cnt == 4'd0) begin
                        state <= ST_RECOV;
                    end else begin
                        strobe_cnt <= strobe_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // SRAM pin registers. Address and write data are captured at grant
    // and held through RECOV for hold time; they stay put while idle.
    // WE_n is registered so the strobe edges are glitch-free, and the
    // async reset forces it high immediately even mid-write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
            we_n_q <= 1'b1;
            dout_q <= 8'h00;
            doe_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        addr_q <= pick_addr;
                        doe_q  <= pick_we;
                        if (pick_we) begin
                            dout_q <= pick_wdata;
                        end
                    end
                end
                ST_ADDR: begin
                    we_n_q <= !gnt_we;
                end
                ST_STROBE: begin
                    if (strobe_cnt == 4'd0) begin
                        we_n_q <= 1'b1;
                    end
                end
                default: begin
                    doe_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Completion: ack pulses during RECOV; read data is sampled on the
    // edge leaving the last strobe clock so it is valid with the ack.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            vga_ack_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            vga_rdata_q <= 8'h00;
            cpu_rdata_q <= 8'h00;
            dma_rdata_q <= 8'h00;
        end else begin
            vga_ack_q <= strobe_done && (gnt_port == PORT_VGA);
            cpu_ack_q <= strobe_done && (gnt_port == PORT_CPU);
            dma_ack_q <= strobe_done && (gnt_port == PORT_DMA);
            if (strobe_done && !gnt_we) begin
                case (gnt_port)
                    PORT_VGA: vga_rdata_q <= bus.sram_din;
                    PORT_CPU: cpu_rdata_q <= bus.sram_din;
                    default:  dma_rdata_q <= bus.sram_din;
                endcase
            end
        end
    end

    assign bus.SRAM_ADDR = addr_q;
    assign bus.SRAM_WE_n = we_n_q;
    assign bus.sram_dout = dout_q;
    assign bus.sram_doe  = doe_q;
    assign bus.busy      = (state != ST_IDLE);

    assign bus.vga_ack   = vga_ack_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.dma_ack   = dma_ack_q;
    assign bus.vga_rdata = vga_rdata_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Purpose: self-checking bench for sram_arbiter (default build plus ACCESS_CYCLES=1/15 builds).
// Latency: checks ack latency, strobe width and back-to-back access period.
// Backpressure: requester agents hold each request until ack, then reload or drop.
module tb_sram_arbiter;

    localparam int AW = 21;
    localparam int AC = 2;

    logic clk_100 = 1'b0;
    logic reset_n;
    always #5 clk_100 = ~clk_100;

    int cyc = 0;
    always @(posedge clk_100) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    sram_arbiter_if #(.ADDR_W(AW)) ifm ();
    sram_arbiter_if #(.ADDR_W(AW)) if1 ();
    sram_arbiter_if #(.ADDR_W(AW)) if15 ();

    sram_arbiter #(.ADDR_W(AW), .ACCESS_CYCLES(AC)) dut (
        .clk_100 (clk_100),
        .reset_n (reset_n),
        .bus     (ifm)
    );
    sram_arbiter #(.ADDR_W(AW), .ACCESS_CYCLES(1)) dut_ac1 (
        .clk_100 (clk_100),
        .reset_n (reset_n),
        .bus     (if1)
    );
    sram_arbiter #(.ADDR_W(AW), .ACCESS_CYCLES(15)) dut_ac15 (
        .clk_100 (clk_100),
        .reset_n (reset_n),
        .bus     (if15)
    );

    // ---------------- main DUT drive, indexed 0=VGA 1=CPU 2=DMA ----------------
    logic          req   [3];
    logic          we    [3];
    logic [AW-1:0] addr  [3];
    logic [7:0]    wdata [3];
    logic [7:0]    din_m;
    logic [2:0]    ack_v;
    logic [7:0]    rdata_v [3];

    assign ifm.vga_req   = req[0];
    assign ifm.vga_addr  = addr[0];
    assign ifm.cpu_req   = req[1];
    assign ifm.cpu_we    = we[1];
    assign ifm.cpu_addr  = addr[1];
    assign ifm.cpu_wdata = wdata[1];
    assign ifm.dma_req   = req[2];
    assign ifm.dma_we    = we[2];
    assign ifm.dma_addr  = addr[2];
    assign ifm.dma_wdata = wdata[2];
    assign ifm.sram_din  = din_m;
    assign ack_v         = {ifm.dma_ack, ifm.cpu_ack, ifm.vga_ack};
    assign rdata_v[0]    = ifm.vga_rdata;
    assign rdata_v[1]    = ifm.cpu_rdata;
    assign rdata_v[2]    = ifm.dma_rdata;

    // ---------------- aux DUTs: one fixed CPU write each ----------------
    logic aux_req [2];
    assign if1.vga_req    = 1'b0;
    assign if1.vga_addr   = '0;
    assign if1.cpu_req    = aux_req[0];
    assign if1.cpu_we     = 1'b1;
    assign if1.cpu_addr   = 21'h0ABCD;
    assign if1.cpu_wdata  = 8'hE7;
    assign if1.dma_req    = 1'b0;
    assign if1.dma_we     = 1'b0;
    assign if1.dma_addr   = '0;
    assign if1.dma_wdata  = 8'h00;
    assign if1.sram_din   = 8'h00;
    assign if15.vga_req   = 1'b0;
    assign if15.vga_addr  = '0;
    assign if15.cpu_req   = aux_req[1];
    assign if15.cpu_we    = 1'b1;
    assign if15.cpu_addr  = 21'h0ABCD;
    assign if15.cpu_wdata = 8'hE7;
    assign if15.dma_req   = 1'b0;
    assign if15.dma_we    = 1'b0;
    assign if15.dma_addr  = '0;
    assign if15.dma_wdata = 8'h00;
    assign if15.sram_din  = 8'h00;

    // ---------------- stimulus / scoreboard ----------------
    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [7:0]    d;
    } stim_t;

    typedef struct {
        int            port;
        logic          w;
        logic [AW-1:0] a;
        logic [7:0]    d;
        int            lat;   // -1: not checked
        int            gap;   // ack-to-previous-ack of same port, -1: not checked
    } exp_t;

    stim_t      stim_q [3][$];
    exp_t       exp_q [$];
    int         req_cyc  [3];
    int         last_ack [3];
    logic       done     [3];
    logic [7:0] mem [logic [AW-1:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] pat(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    task automatic issue(input int port, input logic w, input logic [AW-1:0] a,
                         input logic [7:0] d, input int lat, input int gap);
        stim_t s;
        exp_t  e;
        s.w = w; s.a = a; s.d = d;
        e.port = port; e.w = w; e.a = a; e.d = d; e.lat = lat; e.gap = gap;
        stim_q[port].push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || stim_q[0].size() != 0 || stim_q[1].size() != 0 ||
                stim_q[2].size() != 0 || req[0] || req[1] || req[2]) && n < max_cyc) begin
            @(negedge clk_100);
            n++;
        end
        if (n >= max_cyc) begin
            check("timeout_idle", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            for (int p = 0; p < 3; p++) stim_q[p].delete();
        end
        repeat (2) @(negedge clk_100);
    endtask

    // Requester agents: present the next queued request, hold it until ack,
    // and change it only in the cycle after ack.
    initial begin : agents
        stim_t s;
        for (int p = 0; p < 3; p++) begin
            req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; wdata[p] = 8'h00;
            done[p] = 1'b0; req_cyc[p] = 0; last_ack[p] = 0;
        end
        forever begin
            @(posedge clk_100);
            #1;
            for (int p = 0; p < 3; p++) begin
                if (!reset_n) begin
                    req[p]  = 1'b0;
                    done[p] = 1'b0;
                end else if (req[p] && ack_v[p]) begin
                    done[p] = 1'b1;
                end else if (!req[p] || done[p]) begin
                    done[p] = 1'b0;
                    req[p]  = 1'b0;
                    if (stim_q[p].size() > 0) begin
                        s          = stim_q[p].pop_front();
                        req[p]     = 1'b1;
                        we[p]      = s.w;
                        addr[p]    = s.a;
                        wdata[p]   = s.d;
                        req_cyc[p] = cyc;
                    end
                end
            end
        end
    end

    // SRAM model and output monitor, sampled mid-cycle.
    initial begin : monitor
        int   we_run;
        logic doe_seen;
        exp_t e;
        we_run   = 0;
        doe_seen = 1'b0;
        din_m    = 8'h00;
        forever begin
            @(negedge clk_100);
            if (!reset_n) begin
                we_run   = 0;
                doe_seen = 1'b0;
            end else begin
                if (ifm.SRAM_WE_n == 1'b0) begin
                    mem[ifm.SRAM_ADDR] = ifm.sram_dout;
                    we_run++;
                    check("doe_in_strobe", 32'(ifm.sram_doe), 32'd1);
                end else if (we_run > 0) begin
                    check("we_low_len", 32'(we_run), 32'(AC));
                    if (exp_q.size() == 0) begin
                        check("unexp_write", 32'd1, 32'd0);
                    end else begin
                        check("we_on_write", 32'(exp_q[0].w), 32'd1);
                        check("wr_addr", 32'(ifm.SRAM_ADDR), 32'(exp_q[0].a));
                        check("wr_data", 32'(ifm.sram_dout), 32'(exp_q[0].d));
                    end
                    we_run = 0;
                end
                if (ifm.sram_doe) doe_seen = 1'b1;
                din_m = mem.exists(ifm.SRAM_ADDR) ? mem[ifm.SRAM_ADDR] : pat(ifm.SRAM_ADDR);
                if (ack_v != 3'b000) begin
                    if (exp_q.size() == 0) begin
                        check("unexp_ack", 32'(ack_v), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("ack_port", 32'(ack_v), 32'(3'b001 << e.port));
                        if (e.lat >= 0) check("ack_lat", 32'(cyc - req_cyc[e.port]), 32'(e.lat));
                        if (e.gap >= 0) check("ack_gap", 32'(cyc - last_ack[e.port]), 32'(e.gap));
                        if (!e.w) begin
                            check("rdata", 32'(rdata_v[e.port]), 32'(e.d));
                            check("rd_doe", 32'(doe_seen), 32'd0);
                        end
                        last_ack[e.port] = cyc;
                    end
                    doe_seen = 1'b0;
                end
            end
        end
    end

    task automatic run_aux(input int g, input int exp_lat);
        int lo;
        int c0;
        int n;
        logic got;
        lo  = 0;
        n   = 0;
        got = 1'b0;
        @(posedge clk_100);
        #1;
        aux_req[g] = 1'b1;
        c0 = cyc;
        while (!got && n < 60) begin
            @(negedge clk_100);
            n++;
            if ((g == 0 ? if1.SRAM_WE_n : if15.SRAM_WE_n) == 1'b0) lo++;
            if ((g == 0 ? if1.cpu_ack : if15.cpu_ack) == 1'b1) begin
                got = 1'b1;
                check(g == 0 ? "ac1_lat" : "ac15_lat", 32'(cyc - c0), 32'(exp_lat));
                check(g == 0 ? "ac1_we_low" : "ac15_we_low", 32'(lo), 32'(exp_lat - 2));
            end
        end
        if (!got) check(g == 0 ? "ac1_timeout" : "ac15_timeout", 32'd0, 32'd1);
        @(posedge clk_100);
        #1;
        aux_req[g] = 1'b0;
        repeat (3) @(negedge clk_100);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        aux_req[0] = 1'b0;
        aux_req[1] = 1'b0;
        reset_n    = 1'b0;
        repeat (3) @(posedge clk_100);
        @(negedge clk_100);
        check("rst_we_n", 32'(ifm.SRAM_WE_n), 32'd1);
        check("rst_doe", 32'(ifm.sram_doe), 32'd0);
        check("rst_acks", 32'(ack_v), 32'd0);
        check("rst_busy", 32'(ifm.busy), 32'd0);
        check("rst_addr", 32'(ifm.SRAM_ADDR), 32'd0);
        check("rst_rdata", 32'(ifm.cpu_rdata), 32'd0);
        check("rst_ac15_we_n", 32'(if15.SRAM_WE_n), 32'd1);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_100);

        // CPU write, then CPU read of a preloaded byte
        issue(1, 1'b1, 21'h1ABCD, 8'h5A, AC + 2, -1);
        wait_idle(100);
        mem[21'h00010] = 8'hC3;
        issue(1, 1'b0, 21'h00010, 8'hC3, AC + 2, -1);
        wait_idle(100);
        repeat (3) @(negedge clk_100);
        check("rdata_hold", 32'(ifm.cpu_rdata), 32'hC3);
        issue(1, 1'b0, 21'h1ABCD, 8'h5A, AC + 2, -1);
        wait_idle(100);

        // Back-to-back DMA at both address extremes, then read both back
        issue(2, 1'b1, 21'h1FFFFF, 8'h11, AC + 2, -1);
        issue(2, 1'b1, 21'h000000, 8'h22, AC + 2, AC + 3);
        issue(2, 1'b0, 21'h1FFFFF, 8'h11, AC + 2, AC + 3);
        issue(2, 1'b0, 21'h000000, 8'h22, AC + 2, AC + 3);
        wait_idle(100);

        // Three-way contention: VGA, then CPU (pointer favours CPU after DMA), then DMA
        issue(0, 1'b0, 21'h00100, pat(21'h00100), AC + 2, -1);
        issue(1, 1'b0, 21'h00200, pat(21'h00200), -1, -1);
        issue(2, 1'b0, 21'h00300, pat(21'h00300), -1, -1);
        wait_idle(100);

        // Continuous CPU+DMA: grants alternate, starting with CPU
        for (int i = 0; i < 3; i++) begin
            issue(1, 1'b1, 21'(32'h04000 + i), 8'(8'h70 + i), -1, -1);
            issue(2, 1'b1, 21'(32'h08000 + i), 8'(8'h90 + i), -1, -1);
        end
        wait_idle(200);
        issue(2, 1'b0, 21'h08001, 8'h91, AC + 2, -1);
        wait_idle(100);

        // Slow/fast strobe builds
        run_aux(0, 3);
        run_aux(1, 17);

        // Reset in the middle of a write strobe
        issue(1, 1'b1, 21'h00777, 8'h55, -1, -1);
        for (int i = 0; i < 20 && ifm.SRAM_WE_n !== 1'b0; i++) @(negedge clk_100);
        check("strobe_reached", 32'(ifm.SRAM_WE_n), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_we_n", 32'(ifm.SRAM_WE_n), 32'd1);
        check("midrst_busy", 32'(ifm.busy), 32'd0);
        check("midrst_ack", 32'(ack_v), 32'd0);
        check("midrst_doe", 32'(ifm.sram_doe), 32'd0);
        exp_q.delete();
        for (int p = 0; p < 3; p++) stim_q[p].delete();
        repeat (2) @(negedge clk_100);
        reset_n = 1'b1;
        repeat (8) @(negedge clk_100);
        check("post_rst_busy", 32'(ifm.busy), 32'd0);
        check("post_rst_ack", 32'(ack_v), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
